// File: rtl/seg_pkg.sv
// Shared 7-segment constants (active-low, bit 6 = a .. bit 0 = g) used by the
// segment decoders and by the display readback logic.
package seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // How many anode lines were active in one sample.
  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_ONE   = 2'd1,
    SEL_MULTI = 2'd2
  } sel_kind_e;

endpackage

// File: rtl/seg_scan_reader_if.sv
// Display bus plus readback status for the scan reader; the driver side owns
// the bus lines, the reader side owns the recovered digits and flags.
interface seg_scan_reader_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    sample_en;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [6:0]              seg_n;
  logic                    clear;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic [NUM_DIGITS-1:0]   digit_blank;
  logic                    pat_err;
  logic                    sel_err;
  logic                    frame_done;

  modport master (
    output sample_en, an_n, seg_n, clear,
    input  digits, digit_valid, digit_blank, pat_err, sel_err, frame_done
  );

  modport slave (
    input  sample_en, an_n, seg_n, clear,
    output digits, digit_valid, digit_blank, pat_err, sel_err, frame_done
  );
endinterface

// File: rtl/seg_pattern_to_hex.sv
// Inverse of the hex-to-segment decoder: maps an active-low a..g pattern back
// to its hex value and flags blank or unrecognised patterns.
module seg_pattern_to_hex
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       value,
  output logic             is_hex,
  output logic             is_blank
);

  always_comb begin
    value    = 4'h0;
    is_hex   = 1'b1;
    is_blank = 1'b0;
    case (pattern)
      SEG_0:     value = 4'h0;
      SEG_1:     value = 4'h1;
      SEG_2:     value = 4'h2;
      SEG_3:     value = 4'h3;
      SEG_4:     value = 4'h4;
      SEG_5:     value = 4'h5;
      SEG_6:     value = 4'h6;
      SEG_7:     value = 4'h7;
      SEG_8:     value = 4'h8;
      SEG_9:     value = 4'h9;
      SEG_A:     value = 4'hA;
      SEG_B:     value = 4'hB;
      SEG_C:     value = 4'hC;
      SEG_D:     value = 4'hD;
      SEG_E:     value = 4'hE;
      SEG_F:     value = 4'hF;
      SEG_BLANK: begin
        is_hex   = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_hex = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_reader.sv
// Multiplexed 7-segment readback: debounces each (digit, pattern) sample run and
// commits the decoded value into the per-digit slot once it has been stable.
module seg_scan_reader
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  seg_scan_reader_if.slave bus
);

  localparam int              IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [3:0]      STABLE_MAX = 4'(STABLE_CNT);

  logic [NUM_DIGITS-1:0]   an_act;
  sel_kind_e               sel_kind;
  logic [IDX_W-1:0]        sel_idx;

  logic                    cand_vld_q, cand_vld_d;
  logic [IDX_W-1:0]        cand_idx_q, cand_idx_d;
  logic [SEG_W-1:0]        cand_seg_q, cand_seg_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    commit;
  logic                    sel_err_set;

  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [NUM_DIGITS-1:0]   mask_nxt;
  logic                    pat_err_q, pat_err_d;
  logic                    sel_err_q, sel_err_d;
  logic                    frame_done_q, frame_done_d;

  logic [3:0]              dec_value;
  logic                    dec_is_hex;
  logic                    dec_is_blank;

  assign an_act = ~bus.an_n;

  always_comb begin
    sel_kind = SEL_NONE;
    sel_idx  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_act[i]) begin
        if (sel_kind == SEL_NONE) begin
          sel_kind = SEL_ONE;
          sel_idx  = IDX_W'(i);
        end else begin
          sel_kind = SEL_MULTI;
        end
      end
    end
  end

  // Candidate tracking: a run is a sequence of samples with the same digit and pattern.
  always_comb begin
    cand_vld_d  = cand_vld_q;
    cand_idx_d  = cand_idx_q;
    cand_seg_d  = cand_seg_q;
    cnt_d       = cnt_q;
    commit      = 1'b0;
    sel_err_set = 1'b0;
    if (bus.clear) begin
      cand_vld_d = 1'b0;
      cand_idx_d = '0;
      cand_seg_d = '0;
      cnt_d      = 4'd0;
    end else if (bus.sample_en) begin
      case (sel_kind)
        SEL_ONE: begin
          if (cand_vld_q && cand_idx_q == sel_idx && cand_seg_q == bus.seg_n) begin
            if (cnt_q < STABLE_MAX) begin
              cnt_d  = cnt_q + 4'd1;
              commit = (cnt_q + 4'd1 == STABLE_MAX);
            end
          end else begin
            cand_vld_d = 1'b1;
            cand_idx_d = sel_idx;
            cand_seg_d = bus.seg_n;
            cnt_d      = 4'd1;
            commit     = (STABLE_MAX == 4'd1);
          end
        end
        SEL_MULTI: begin
          sel_err_set = 1'b1;
          cand_vld_d  = 1'b0;
          cand_idx_d  = '0;
          cand_seg_d  = '0;
          cnt_d       = 4'd0;
        end
        default: begin
          cand_vld_d = 1'b0;
          cand_idx_d = '0;
          cand_seg_d = '0;
          cnt_d      = 4'd0;
        end
      endcase
    end
  end

  // On a commit the candidate already holds the committing pattern.
  seg_pattern_to_hex u_dec (
    .pattern  (cand_seg_d),
    .value    (dec_value),
    .is_hex   (dec_is_hex),
    .is_blank (dec_is_blank)
  );

  always_comb begin
    digits_d     = digits_q;
    valid_d      = valid_q;
    blank_d      = blank_q;
    mask_d       = mask_q;
    mask_nxt     = mask_q;
    pat_err_d    = pat_err_q;
    sel_err_d    = sel_err_q;
    frame_done_d = 1'b0;
    if (bus.clear) begin
      valid_d   = '0;
      blank_d   = '0;
      mask_d    = '0;
      pat_err_d = 1'b0;
      sel_err_d = 1'b0;
    end else begin
      if (sel_err_set) begin
        sel_err_d = 1'b1;
      end
      if (commit) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (cand_idx_d == IDX_W'(i)) begin
            mask_nxt[i] = 1'b1;
            valid_d[i]  = dec_is_hex;
            blank_d[i]  = dec_is_blank;
            if (dec_is_hex) begin
              digits_d[4*i +: 4] = dec_value;
            end
          end
        end
        if (!dec_is_hex && !dec_is_blank) begin
          pat_err_d = 1'b1;
        end
        // A full mask restarts immediately so the next commit opens a new frame.
        if (&mask_nxt) begin
          mask_d       = '0;
          frame_done_d = 1'b1;
        end else begin
          mask_d = mask_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_vld_q   <= 1'b0;
      cand_idx_q   <= '0;
      cand_seg_q   <= '0;
      cnt_q        <= 4'd0;
      digits_q     <= '0;
      valid_q      <= '0;
      blank_q      <= '0;
      mask_q       <= '0;
      pat_err_q    <= 1'b0;
      sel_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cand_vld_q   <= cand_vld_d;
      cand_idx_q   <= cand_idx_d;
      cand_seg_q   <= cand_seg_d;
      cnt_q        <= cnt_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      blank_q      <= blank_d;
      mask_q       <= mask_d;
      pat_err_q    <= pat_err_d;
      sel_err_q    <= sel_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.digit_blank = blank_q;
  assign bus.pat_err     = pat_err_q;
  assign bus.sel_err     = sel_err_q;
  assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed bench for seg_scan_reader: one STABLE_CNT=4 instance and one
// STABLE_CNT=1 instance, driven on the falling edge and checked 1 time unit after the rising edge.
module tb_seg_scan_reader;

  localparam logic [6:0] P_0     = 7'b0000001;
  localparam logic [6:0] P_1     = 7'b1001111;
  localparam logic [6:0] P_2     = 7'b0010010;
  localparam logic [6:0] P_3     = 7'b0000110;
  localparam logic [6:0] P_7     = 7'b0001111;
  localparam logic [6:0] P_8     = 7'b0000000;
  localparam logic [6:0] P_9     = 7'b0000100;
  localparam logic [6:0] P_A     = 7'b0000010;
  localparam logic [6:0] P_B     = 7'b1100000;
  localparam logic [6:0] P_BAD   = 7'b1111110;
  localparam logic [6:0] P_BLANK = 7'b1111111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seg_scan_reader_if #(.NUM_DIGITS(4)) ifa ();
  seg_scan_reader_if #(.NUM_DIGITS(4)) ifb ();

  seg_scan_reader #(.NUM_DIGITS(4), .STABLE_CNT(4)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  seg_scan_reader #(.NUM_DIGITS(4), .STABLE_CNT(1)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic stepa(input logic [3:0] an, input logic [6:0] seg, input logic clr);
    @(negedge clk);
    ifa.sample_en = 1'b1;
    ifa.an_n      = an;
    ifa.seg_n     = seg;
    ifa.clear     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic runa(input logic [3:0] an, input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) stepa(an, seg, 1'b0);
  endtask

  task automatic stepb(input logic [3:0] an, input logic [6:0] seg);
    @(negedge clk);
    ifb.sample_en = 1'b1;
    ifb.an_n      = an;
    ifb.seg_n     = seg;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    ifa.sample_en = 1'b0;
    ifa.clear     = 1'b0;
    ifb.sample_en = 1'b0;
    ifb.clear     = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    ifa.sample_en = 1'b0;
    ifb.sample_en = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifa.sample_en = 1'b0; ifa.an_n = 4'hF; ifa.seg_n = P_BLANK; ifa.clear = 1'b0;
    ifb.sample_en = 1'b0; ifb.an_n = 4'hF; ifb.seg_n = P_BLANK; ifb.clear = 1'b0;
    do_reset();

    chk("rst_digits", 32'(ifa.digits), 32'h0000);
    chk("rst_valid", 32'(ifa.digit_valid), 32'h0);
    chk("rst_blank", 32'(ifa.digit_blank), 32'h0);
    chk("rst_pat_err", 32'(ifa.pat_err), 32'h0);
    chk("rst_sel_err", 32'(ifa.sel_err), 32'h0);
    chk("rst_frame_done", 32'(ifa.frame_done), 32'h0);

    // Four stable samples of '2' on digit 0
    runa(4'b1110, P_2, 3);
    chk("two_3rd_valid", 32'(ifa.digit_valid), 32'h0);
    stepa(4'b1110, P_2, 1'b0);
    chk("two_4th_digits", 32'(ifa.digits), 32'h0002);
    chk("two_4th_valid", 32'(ifa.digit_valid), 32'h1);
    stepa(4'b1110, P_2, 1'b0);
    chk("two_5th_digits", 32'(ifa.digits), 32'h0002);
    chk("two_5th_valid", 32'(ifa.digit_valid), 32'h1);
    chk("two_5th_fd", 32'(ifa.frame_done), 32'h0);

    // Full frame 3,0,7,B
    runa(4'b1110, P_3, 4);
    chk("frm_slot0", 32'(ifa.digits), 32'h0003);
    runa(4'b1101, P_0, 4);
    chk("frm_slot1_valid", 32'(ifa.digit_valid), 32'h3);
    runa(4'b1011, P_7, 4);
    chk("frm_slot2_digits", 32'(ifa.digits), 32'h0703);
    chk("frm_slot2_fd", 32'(ifa.frame_done), 32'h0);
    runa(4'b0111, P_B, 3);
    chk("frm_b3_fd", 32'(ifa.frame_done), 32'h0);
    stepa(4'b0111, P_B, 1'b0);
    chk("frm_digits", 32'(ifa.digits), 32'hB703);
    chk("frm_valid", 32'(ifa.digit_valid), 32'hF);
    chk("frm_fd_pulse", 32'(ifa.frame_done), 32'h1);
    idle();
    chk("frm_fd_drop", 32'(ifa.frame_done), 32'h0);

    // Short run of '2' interrupted by '3'
    runa(4'b1110, P_2, 3);
    chk("short_no_commit", 32'(ifa.digits), 32'hB703);
    runa(4'b1110, P_3, 4);
    chk("short_then3", 32'(ifa.digits), 32'hB703);
    chk("short_valid", 32'(ifa.digit_valid), 32'hF);

    // Invalid pattern on slot 1, blank on slot 2
    runa(4'b1101, P_BAD, 4);
    chk("bad_pat_err", 32'(ifa.pat_err), 32'h1);
    chk("bad_valid", 32'(ifa.digit_valid), 32'hD);
    chk("bad_digits", 32'(ifa.digits), 32'hB703);
    runa(4'b1011, P_BLANK, 4);
    chk("blank_mask", 32'(ifa.digit_blank), 32'h4);
    chk("blank_valid", 32'(ifa.digit_valid), 32'h9);
    chk("blank_digits", 32'(ifa.digits), 32'hB703);
    chk("blank_pat_sticky", 32'(ifa.pat_err), 32'h1);

    // Multi-anode sample breaks a run of '9' on slot 3
    runa(4'b0111, P_9, 2);
    stepa(4'b1100, P_9, 1'b0);
    chk("sel_err_set", 32'(ifa.sel_err), 32'h1);
    runa(4'b0111, P_9, 2);
    chk("sel_restart_digits", 32'(ifa.digits), 32'hB703);
    chk("sel_restart_fd", 32'(ifa.frame_done), 32'h0);
    runa(4'b0111, P_9, 2);
    chk("sel_commit_digits", 32'(ifa.digits), 32'h9703);
    chk("sel_commit_fd", 32'(ifa.frame_done), 32'h1);

    // clear together with what would be the committing sample
    runa(4'b1110, P_8, 3);
    stepa(4'b1110, P_8, 1'b1);
    chk("clr_valid", 32'(ifa.digit_valid), 32'h0);
    chk("clr_blank", 32'(ifa.digit_blank), 32'h0);
    chk("clr_pat_err", 32'(ifa.pat_err), 32'h0);
    chk("clr_sel_err", 32'(ifa.sel_err), 32'h0);
    chk("clr_digits", 32'(ifa.digits), 32'h9703);
    stepa(4'b1110, P_8, 1'b0);
    chk("clr_after1_valid", 32'(ifa.digit_valid), 32'h0);
    runa(4'b1110, P_8, 3);
    chk("clr_after4_digits", 32'(ifa.digits), 32'h9708);
    chk("clr_after4_valid", 32'(ifa.digit_valid), 32'h1);

    // Reset between samples 2 and 3 of a run
    idle();
    runa(4'b1110, P_A, 2);
    do_reset();
    chk("mid_rst_digits", 32'(ifa.digits), 32'h0000);
    runa(4'b1110, P_A, 2);
    chk("mid_rst_no_commit", 32'(ifa.digit_valid), 32'h0);
    runa(4'b1110, P_A, 2);
    chk("mid_rst_recommit", 32'(ifa.digits), 32'h000A);
    chk("mid_rst_valid", 32'(ifa.digit_valid), 32'h1);
    idle();

    // STABLE_CNT=1 instance: commit on the first sample
    stepb(4'b0111, P_9);
    chk("s1_digits", 32'(ifb.digits), 32'h9000);
    chk("s1_valid", 32'(ifb.digit_valid), 32'h8);
    stepb(4'b0111, P_9);
    chk("s1_repeat_digits", 32'(ifb.digits), 32'h9000);
    stepb(4'b1110, P_1);
    chk("s1_slot0_digits", 32'(ifb.digits), 32'h9001);
    chk("s1_slot0_valid", 32'(ifb.digit_valid), 32'h9);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
